// File: rtl/core_v_mini_mcu_pkg.sv
// Shared MCU-level types; pad placement side for pad-bank instances.
package core_v_mini_mcu_pkg;

    typedef enum logic [1:0] {
        TOP    = 2'd0,
        RIGHT  = 2'd1,
        BOTTOM = 2'd2,
        LEFT   = 2'd3
    } pad_side_e;

endpackage

// File: rtl/IOBUF.sv
// Behavioural stand-in for the Xilinx IOBUF primitive (T=1 releases the pad).
module IOBUF (
    output logic O,
    inout  wire  IO,
    input  logic I,
    input  logic T
);

    assign IO = T ? 1'bz : I;
    assign O  = IO;

endmodule

// File: rtl/pad_bank_inout_xilinx.sv
// Bank of independent bidirectional pads: registered drive path through an
// IOBUF, input synchroniser, optional debounce/inversion and edge pulses.
module pad_bank_inout_xilinx #(
    parameter int unsigned                     NUM_PADS        = 4,
    parameter int unsigned                     PADATTR         = 16,
    parameter int unsigned                     SYNC_STAGES     = 2,
    parameter int unsigned                     DEBOUNCE_CYCLES = 8,
    parameter core_v_mini_mcu_pkg::pad_side_e  SIDE            = core_v_mini_mcu_pkg::TOP
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_PADS-1:0]           pad_in_i,
    input  logic [NUM_PADS-1:0]           pad_oe_i,
    output logic [NUM_PADS-1:0]           pad_out_o,
    output logic [NUM_PADS-1:0]           pad_rise_o,
    output logic [NUM_PADS-1:0]           pad_fall_o,
    inout  wire  [NUM_PADS-1:0]           pad_io,
    input  logic [NUM_PADS*PADATTR-1:0]   pad_attributes_i
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Registered pad controls, exposed as flat vectors for observation.
    logic [NUM_PADS-1:0] w_oe;
    logic [NUM_PADS-1:0] w_drv;

    // Placement side carries no function in this bank.
    logic w_unused_side;
    assign w_unused_side = ^{SIDE};

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad

        logic [PADATTR-1:0]     w_attr;
        logic                   w_deb_en;
        logic                   w_inv;
        logic                   w_od;
        logic                   w_dis;
        logic                   w_pad_o;
        logic                   w_lev;
        logic                   w_stable_nxt;
        logic [CNT_W-1:0]       w_cnt_nxt;

        logic                   r_oe;
        logic                   r_drv;
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_stable;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_deb_en_q;
        logic                   r_inv_q;
        logic                   r_rise;
        logic                   r_fall;

        assign w_attr   = pad_attributes_i[i*PADATTR +: PADATTR];
        assign w_deb_en = w_attr[0];
        assign w_inv    = w_attr[1];
        assign w_od     = w_attr[2];
        assign w_dis    = w_attr[3];

        if (PADATTR > 4) begin : g_attr_hi
            logic w_unused_attr;
            assign w_unused_attr = ^w_attr[PADATTR-1:4];
        end

        // Drive path: push-pull follows pad_in_i, open-drain only pulls low.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_oe  <= 1'b0;
                r_drv <= 1'b0;
            end else if (w_od) begin
                r_oe  <= pad_oe_i[i] & ~pad_in_i[i] & ~w_dis;
                r_drv <= 1'b0;
            end else begin
                r_oe  <= pad_oe_i[i] & ~w_dis;
                r_drv <= pad_in_i[i];
            end
        end

        IOBUF u_iobuf (
            .O  (w_pad_o),
            .IO (pad_io[i]),
            .I  (r_drv),
            .T  (~r_oe)
        );

        // Input synchroniser; only the last stage is used downstream.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_pad_o};
            end
        end

        assign w_lev = r_sync[SYNC_STAGES-1] ^ w_inv;

        // Debounce next state; attribute changes restart any pending count.
        always_comb begin
            w_stable_nxt = r_stable;
            w_cnt_nxt    = '0;
            if (!w_deb_en) begin
                w_stable_nxt = w_lev;
            end else if ((w_deb_en != r_deb_en_q) || (w_inv != r_inv_q)) begin
                w_cnt_nxt = '0;
            end else if (w_lev != r_stable) begin
                if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    w_stable_nxt = w_lev;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        end

        // Debounce state and edge pulses aligned with the new stable level.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_stable   <= 1'b0;
                r_cnt      <= '0;
                r_deb_en_q <= 1'b0;
                r_inv_q    <= 1'b0;
                r_rise     <= 1'b0;
                r_fall     <= 1'b0;
            end else begin
                r_stable   <= w_stable_nxt;
                r_cnt      <= w_cnt_nxt;
                r_deb_en_q <= w_deb_en;
                r_inv_q    <= w_inv;
                r_rise     <= w_stable_nxt & ~r_stable;
                r_fall     <= ~w_stable_nxt & r_stable;
            end
        end

        assign w_oe[i]       = r_oe;
        assign w_drv[i]      = r_drv;
        assign pad_out_o[i]  = r_stable;
        assign pad_rise_o[i] = r_rise;
        assign pad_fall_o[i] = r_fall;
    end

endmodule

// File: tb/tb_pad_bank_inout_xilinx.sv
// Directed bench for pad_bank_inout_xilinx; inputs and checks on the falling edge.
module tb_pad_bank_inout_xilinx;

    localparam int unsigned NP = 4;
    localparam int unsigned PA = 16;
    localparam int unsigned SS = 2;
    localparam int unsigned DC = 8;

    logic               clk;
    logic               rst_n;
    logic [NP-1:0]      pad_in;
    logic [NP-1:0]      pad_oe;
    logic [NP*PA-1:0]   attr;
    logic [NP-1:0]      pad_out;
    logic [NP-1:0]      pad_rise;
    logic [NP-1:0]      pad_fall;
    wire  [NP-1:0]      pad_io;
    logic [NP-1:0]      r_ext_en;
    logic [NP-1:0]      r_ext_val;

    int n_checks;
    int n_fail;

    pad_bank_inout_xilinx #(
        .NUM_PADS        (NP),
        .PADATTR         (PA),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .SIDE            (core_v_mini_mcu_pkg::TOP)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .pad_in_i         (pad_in),
        .pad_oe_i         (pad_oe),
        .pad_out_o        (pad_out),
        .pad_rise_o       (pad_rise),
        .pad_fall_o       (pad_fall),
        .pad_io           (pad_io),
        .pad_attributes_i (attr)
    );

    // External drivers standing in for off-chip logic on the pads.
    for (genvar k = 0; k < NP; k++) begin : g_ext
        assign pad_io[k] = r_ext_en[k] ? r_ext_val[k] : 1'bz;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_attr(input int ch, input logic [PA-1:0] val);
        attr[ch*PA +: PA] = val;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        pad_in    = 4'b1100;
        pad_oe    = 4'b1100;
        attr      = '0;
        r_ext_en  = 4'b0011;
        r_ext_val = 4'b0000;

        // Reset: pads released even with enables requested.
        step(3);
        chk("rst_oe",   32'(dut.w_oe),  32'h0);
        chk("rst_drv",  32'(dut.w_drv), 32'h0);
        chk("rst_out",  32'(pad_out),   32'h0);
        chk("rst_rise", 32'(pad_rise),  32'h0);
        chk("rst_fall", 32'(pad_fall),  32'h0);
        pad_in = '0;
        pad_oe = '0;
        rst_n  = 1'b1;
        step(4);

        // Channel 0, no debounce: pad change reaches pad_out_o after SS+1 edges.
        r_ext_val[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk($sformatf("a_out_%0d", k),  32'(pad_out[0]),  32'(k >= 3));
            chk($sformatf("a_rise_%0d", k), 32'(pad_rise[0]), 32'(k == 3));
        end
        r_ext_val[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk($sformatf("a_fout_%0d", k),  32'(pad_out[0]),  32'(k < 3));
            chk($sformatf("a_fall_%0d", k),  32'(pad_fall[0]), 32'(k == 3));
            chk($sformatf("a_frise_%0d", k), 32'(pad_rise[0]), 32'h0);
        end

        // Channel 1, debounce: a 5-cycle glitch is rejected.
        set_attr(1, 16'h0001);
        step(2);
        for (int k = 0; k < 20; k++) begin
            r_ext_val[1] = (k < 5);
            step(1);
            chk($sformatf("b_glitch_out_%0d", k),  32'(pad_out[1]),  32'h0);
            chk($sformatf("b_glitch_rise_%0d", k), 32'(pad_rise[1]), 32'h0);
        end
        // Held high: lev rises after SS edges, stable after DC more.
        r_ext_val[1] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            chk($sformatf("b_out_%0d", k),  32'(pad_out[1]),  32'(k >= int'(SS + DC)));
            chk($sformatf("b_rise_%0d", k), 32'(pad_rise[1]), 32'(k == int'(SS + DC)));
        end

        // Channel 2, open drain: low drives, high releases, I stays 0.
        set_attr(2, 16'h0004);
        pad_oe[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic v;
            v = (k == 1) || (k == 3) || (k == 4);
            pad_in[2] = v;
            step(1);
            chk($sformatf("c_oe_%0d", k),  32'(dut.w_oe[2]),  32'(!v));
            chk($sformatf("c_drv_%0d", k), 32'(dut.w_drv[2]), 32'h0);
            if (!v) chk($sformatf("c_pad_%0d", k), 32'(pad_io[2]), 32'h0);
        end
        pad_oe[2] = 1'b0;

        // Channel 3, push-pull: OUT_DIS holds the pad released.
        set_attr(3, 16'h0008);
        pad_oe[3] = 1'b1;
        pad_in[3] = 1'b1;
        step(1);
        chk("d_dis_oe", 32'(dut.w_oe[3]), 32'h0);
        step(1);
        chk("d_dis_oe2", 32'(dut.w_oe[3]), 32'h0);
        set_attr(3, 16'h0000);
        step(1);
        chk("d_en_oe",  32'(dut.w_oe[3]),  32'h1);
        chk("d_en_drv", 32'(dut.w_drv[3]), 32'h1);
        chk("d_pad_hi", 32'(pad_io[3]),    32'h1);
        pad_in[3] = 1'b0;
        step(1);
        chk("d_pad_lo", 32'(pad_io[3]),    32'h0);
        pad_oe[3] = 1'b0;

        // Channel 0: INV flip on a low pad shows up one edge later.
        set_attr(0, 16'h0002);
        step(1);
        chk("e_out1",  32'(pad_out[0]),  32'h1);
        chk("e_rise1", 32'(pad_rise[0]), 32'h1);
        chk("e_fall1", 32'(pad_fall[0]), 32'h0);
        step(1);
        chk("e_out2",  32'(pad_out[0]),  32'h1);
        chk("e_rise2", 32'(pad_rise[0]), 32'h0);
        set_attr(0, 16'h0000);
        step(1);
        chk("e_out3",  32'(pad_out[0]),  32'h0);
        chk("e_fall3", 32'(pad_fall[0]), 32'h1);

        // Channel 1: reset in the middle of a debounce count.
        r_ext_val[1] = 1'b0;
        step(SS + DC + 2);
        chk("f_low", 32'(pad_out[1]), 32'h0);
        r_ext_val[1] = 1'b1;
        step(5);
        rst_n = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk($sformatf("f_rst_out_%0d", k),  32'(pad_out),  32'h0);
            chk($sformatf("f_rst_rise_%0d", k), 32'(pad_rise), 32'h0);
            chk($sformatf("f_rst_fall_%0d", k), 32'(pad_fall), 32'h0);
        end
        rst_n = 1'b1;
        // Counted from the last cycle spent in reset (k+1 cycles elapsed).
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk($sformatf("f_out_%0d", k),  32'(pad_out[1]),  32'((k + 1) >= int'(SS + DC + 1)));
            chk($sformatf("f_rise_%0d", k), 32'(pad_rise[1]), 32'((k + 1) == int'(SS + DC + 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
